// File: rtl/rpc2_ctrl_fifo_ctrl_if.sv
// Push/pop bundle between the controller datapath and one rpc2 FIFO control stage.
// The datapath side uses the master modport and the FIFO control stage uses the slave modport.
interface rpc2_ctrl_fifo_ctrl_if #(
  parameter int FIFO_ADDR_BITS  = 4,
  parameter int FIFO_DATA_WIDTH = 44
);
  logic                       wr_en;
  logic [FIFO_DATA_WIDTH-1:0] wr_data;
  logic                       full;
  logic                       almost_full;
  logic                       rd_en;
  logic [FIFO_DATA_WIDTH-1:0] rd_data;
  logic                       empty;
  logic [FIFO_ADDR_BITS:0]    count;
  logic                       ovf_err;
  logic                       udf_err;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, empty, count, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, empty, count, ovf_err, udf_err
  );
endinterface

// File: rtl/rpc2_ctrl_fifo_ctrl.sv
// rpc2 FIFO control stage. It drives one DPRAM, using port A for writes and port B for reads.
// It presents a first-word-fall-through interface, and the RAM's registered B output serves as the head word.
// Optional sticky overflow/underflow flags are enabled by defining RPC2_CTRL_FIFO_ERR_FLAG_EN.
module rpc2_ctrl_fifo_ctrl #(
  parameter int FIFO_ADDR_BITS  = 4,
  parameter int FIFO_DATA_WIDTH = 44,
  parameter int ALMOST_FULL_LVL = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  rpc2_ctrl_fifo_ctrl_if.slave       fifo,
  output logic                       ram_ceia_n,
  output logic [FIFO_ADDR_BITS-1:0]  ram_ia,
  output logic [FIFO_DATA_WIDTH-1:0] ram_idata,
  output logic                       ram_cejb_n,
  output logic [FIFO_ADDR_BITS-1:0]  ram_jb,
  input  logic [FIFO_DATA_WIDTH-1:0] ram_odata
);
  localparam int PTR_W = FIFO_ADDR_BITS + 1;
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;

  logic [PTR_W-1:0] wptr_reg;
  logic [PTR_W-1:0] rptr_reg;
  logic             head_vld_reg;
  logic             head_vld_next;
  logic [PTR_W-1:0] ram_words;
  logic [PTR_W-1:0] count_w;
  logic             full_w;
  logic             push;
  logic             pop;
  logic             fetch;

  // The extra wrap bit lets the unsigned difference separate a full RAM from an empty one.
  assign ram_words = wptr_reg - rptr_reg;
  assign full_w    = (ram_words == PTR_W'(DEPTH));
  assign count_w   = ram_words + PTR_W'(head_vld_reg);

  assign push  = fifo.wr_en & ~full_w;
  assign pop   = fifo.rd_en & head_vld_reg;
  // Refill the head whenever it is empty or is being consumed this cycle.
  // ram_words only counts words whose write edge has already passed.
  assign fetch = (ram_words != '0) & (~head_vld_reg | pop);
  assign head_vld_next = fetch | (head_vld_reg & ~pop);

  // The RAM strobes are forced inactive while reset is held, so no write or read is in flight.
  assign ram_ceia_n = ~push | reset;
  assign ram_ia     = wptr_reg[FIFO_ADDR_BITS-1:0];
  assign ram_idata  = fifo.wr_data;
  assign ram_cejb_n = ~fetch | reset;
  assign ram_jb     = rptr_reg[FIFO_ADDR_BITS-1:0];

  assign fifo.rd_data     = ram_odata;
  assign fifo.empty       = ~head_vld_reg;
  assign fifo.full        = full_w;
  assign fifo.count       = count_w;
  assign fifo.almost_full = (count_w >= PTR_W'(ALMOST_FULL_LVL));

  // Pointer and head-valid state. A push moves wptr, and a fetch moves rptr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      head_vld_reg <= 1'b0;
    end else begin
      if (push)  wptr_reg <= wptr_reg + PTR_W'(1);
      if (fetch) rptr_reg <= rptr_reg + PTR_W'(1);
      head_vld_reg <= head_vld_next;
    end
  end

`ifdef RPC2_CTRL_FIFO_ERR_FLAG_EN
  logic ovf_err_reg;
  logic udf_err_reg;

  // Sticky capture of a push while full and of a pop while empty. Only reset clears these flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_err_reg <= 1'b0;
      udf_err_reg <= 1'b0;
    end else begin
      if (fifo.wr_en && full_w) begin
        ovf_err_reg <= 1'b1;
`ifndef SYNTHESIS
        $display("%m: overflow, push while full dropped at %0t", $time);
`endif
      end
      if (fifo.rd_en && !head_vld_reg) begin
        udf_err_reg <= 1'b1;
`ifndef SYNTHESIS
        $display("%m: underflow, pop while empty ignored at %0t", $time);
`endif
      end
    end
  end

  assign fifo.ovf_err = ovf_err_reg;
  assign fifo.udf_err = udf_err_reg;
`else
  assign fifo.ovf_err = 1'b0;
  assign fifo.udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_rpc2_ctrl_fifo_ctrl.sv
// Testbench for rpc2_ctrl_fifo_ctrl. It includes a behavioural DPRAM model and a scoreboard queue.
// A negedge monitor compares rd_data against the queue whenever a pop is presented.
module tb_rpc2_ctrl_fifo_ctrl;
  localparam int AB  = 4;
  localparam int DW  = 44;
  localparam int AFL = 12;
`ifdef RPC2_CTRL_FIFO_ERR_FLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ram_ceia_n;
  logic          ram_cejb_n;
  logic [AB-1:0] ram_ia;
  logic [AB-1:0] ram_jb;
  logic [DW-1:0] ram_idata;
  logic [DW-1:0] ram_odata = '0;
  logic [DW-1:0] mem [0:(1<<AB)-1];

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q [$];

  rpc2_ctrl_fifo_ctrl_if #(.FIFO_ADDR_BITS(AB), .FIFO_DATA_WIDTH(DW)) fifo ();

  rpc2_ctrl_fifo_ctrl #(
    .FIFO_ADDR_BITS (AB),
    .FIFO_DATA_WIDTH(DW),
    .ALMOST_FULL_LVL(AFL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo      (fifo),
    .ram_ceia_n(ram_ceia_n),
    .ram_ia    (ram_ia),
    .ram_idata (ram_idata),
    .ram_cejb_n(ram_cejb_n),
    .ram_jb    (ram_jb),
    .ram_odata (ram_odata)
  );

  always #5 clk = ~clk;

  // DPRAM model: synchronous write on port A, and a registered read on port B that holds while cejb_n is high.
  always @(posedge clk) begin
    if (!ram_ceia_n) mem[ram_ia] <= ram_idata;
    if (!ram_cejb_n) ram_odata <= mem[ram_jb];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor. A pop happens at the next edge, so the head word is compared now.
  always @(negedge clk) begin
    logic [DW-1:0] exp_data;
    if (reset === 1'b0 && fifo.rd_en && !fifo.empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%0h required=no_word", fifo.rd_data);
      end else begin
        exp_data = exp_q.pop_front();
        check("pop_data", 64'(fifo.rd_data), 64'(exp_data));
        $display("pop data=%0h expected=%0h", fifo.rd_data, exp_data);
      end
    end
  end

  initial begin
    reset = 1'b1;
    fifo.wr_en = 1'b0;
    fifo.rd_en = 1'b0;
    fifo.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 64'(fifo.empty), 64'd1);
    check("rst_full", 64'(fifo.full), 64'd0);
    check("rst_afull", 64'(fifo.almost_full), 64'd0);
    check("rst_count", 64'(fifo.count), 64'd0);
    check("rst_ovf", 64'(fifo.ovf_err), 64'd0);
    check("rst_udf", 64'(fifo.udf_err), 64'd0);
    check("rst_ceia_n", 64'(ram_ceia_n), 64'd1);
    check("rst_cejb_n", 64'(ram_cejb_n), 64'd1);
    #2 reset = 1'b0;
    tick();

    // Test 1: a single push shows two-cycle write-to-read latency.
    fifo.wr_en = 1'b1;
    fifo.wr_data = 44'h0A5;
    exp_q.push_back(44'h0A5);
    $display("push data=0a5");
    #1 check("t1_ceia_n_push", 64'(ram_ceia_n), 64'd0);
    tick();
    fifo.wr_en = 1'b0;
    check("t1_empty_t", 64'(fifo.empty), 64'd1);
    check("t1_count_t", 64'(fifo.count), 64'd1);
    tick();
    check("t1_empty_t1", 64'(fifo.empty), 64'd0);
    check("t1_count_t1", 64'(fifo.count), 64'd1);
    check("t1_rd_data", 64'(fifo.rd_data), 64'h0A5);
    fifo.rd_en = 1'b1;
    tick();
    fifo.rd_en = 1'b0;
    check("t1_empty_pop", 64'(fifo.empty), 64'd1);
    check("t1_count_pop", 64'(fifo.count), 64'd0);

    // Test 2: 17 pushes fill the RAM and the head. The 18th push is dropped.
    for (int i = 1; i <= 17; i++) begin
      fifo.wr_en = 1'b1;
      fifo.wr_data = DW'(i);
      exp_q.push_back(DW'(i));
      $display("push data=%0h", i);
      tick();
      check("t2_count", 64'(fifo.count), 64'(i));
      check("t2_full", 64'(fifo.full), 64'(i == 17));
      check("t2_afull", 64'(fifo.almost_full), 64'(i >= AFL));
    end
    fifo.wr_data = 44'hDEAD;
    #1 check("t2_ceia_n_full", 64'(ram_ceia_n), 64'd1);
    tick();
    fifo.wr_en = 1'b0;
    $display("push data=dead while full");
    check("t2_count_drop", 64'(fifo.count), 64'd17);
    check("t2_full_drop", 64'(fifo.full), 64'd1);
    check("t5_ovf", 64'(fifo.ovf_err), 64'(ERR_EN));
    check("t5_udf_clear", 64'(fifo.udf_err), 64'd0);

    // Test 4: at full, a simultaneous pop and push lets the pop through and drops the push.
    fifo.rd_en = 1'b1;
    fifo.wr_en = 1'b1;
    fifo.wr_data = 44'h99;
    tick();
    fifo.rd_en = 1'b0;
    fifo.wr_en = 1'b0;
    check("t4_count", 64'(fifo.count), 64'd16);
    check("t4_full", 64'(fifo.full), 64'd0);
    fifo.wr_en = 1'b1;
    fifo.wr_data = 44'd18;
    exp_q.push_back(44'd18);
    $display("push data=12");
    tick();
    fifo.wr_en = 1'b0;
    check("t4_count_refill", 64'(fifo.count), 64'd17);
    check("t4_full_refill", 64'(fifo.full), 64'd1);
    fifo.rd_en = 1'b1;
    for (int k = 0; k < 40 && !fifo.empty; k++) tick();
    fifo.rd_en = 1'b0;
    check("t4_drained_empty", 64'(fifo.empty), 64'd1);
    check("t4_drained_count", 64'(fifo.count), 64'd0);
    check("t4_queue_left", 64'(exp_q.size()), 64'd0);

    // Test 5: a pop while empty changes no state.
    fifo.rd_en = 1'b1;
    tick();
    fifo.rd_en = 1'b0;
    check("t5_empty", 64'(fifo.empty), 64'd1);
    check("t5_count", 64'(fifo.count), 64'd0);
    check("t5_udf", 64'(fifo.udf_err), 64'(ERR_EN));

    // Test 3: streaming push and pop for 40 words, which wraps the pointers.
    fifo.rd_en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      fifo.wr_en = 1'b1;
      fifo.wr_data = DW'(100 + i);
      exp_q.push_back(DW'(100 + i));
      $display("push data=%0h", 100 + i);
      tick();
      check("t3_count", 64'(fifo.count), (i == 1) ? 64'd1 : 64'd2);
      check("t3_empty", 64'(fifo.empty), 64'(i == 1));
    end
    fifo.wr_en = 1'b0;
    for (int k = 0; k < 10 && !fifo.empty; k++) tick();
    fifo.rd_en = 1'b0;
    check("t3_drained_empty", 64'(fifo.empty), 64'd1);
    check("t3_queue_left", 64'(exp_q.size()), 64'd0);
    check("t5_ovf_sticky", 64'(fifo.ovf_err), 64'(ERR_EN));
    check("t5_udf_sticky", 64'(fifo.udf_err), 64'(ERR_EN));

    // Test 6: an asynchronous reset with 9 words held clears state immediately.
    for (int i = 1; i <= 9; i++) begin
      fifo.wr_en = 1'b1;
      fifo.wr_data = DW'(200 + i);
      $display("push data=%0h", 200 + i);
      tick();
    end
    fifo.wr_en = 1'b0;
    check("t6_count_pre", 64'(fifo.count), 64'd9);
    fifo.wr_en = 1'b1;
    fifo.wr_data = 44'h77;
    #2 reset = 1'b1;
    #1;
    check("t6_rst_empty", 64'(fifo.empty), 64'd1);
    check("t6_rst_count", 64'(fifo.count), 64'd0);
    check("t6_rst_full", 64'(fifo.full), 64'd0);
    check("t6_rst_ceia_n", 64'(ram_ceia_n), 64'd1);
    check("t6_rst_cejb_n", 64'(ram_cejb_n), 64'd1);
    check("t6_rst_ovf", 64'(fifo.ovf_err), 64'd0);
    check("t6_rst_udf", 64'(fifo.udf_err), 64'd0);
    exp_q.delete();
    fifo.wr_en = 1'b0;
    tick();
    #2 reset = 1'b0;
    tick();
    fifo.wr_en = 1'b1;
    fifo.wr_data = 44'h3C;
    exp_q.push_back(44'h3C);
    $display("push data=3c");
    tick();
    fifo.wr_en = 1'b0;
    tick();
    check("t6_empty", 64'(fifo.empty), 64'd0);
    check("t6_rd_data", 64'(fifo.rd_data), 64'h3C);
    check("t6_count", 64'(fifo.count), 64'd1);
    fifo.rd_en = 1'b1;
    tick();
    fifo.rd_en = 1'b0;
    repeat (3) tick();
    check("t6_no_stale_empty", 64'(fifo.empty), 64'd1);
    check("t6_no_stale_count", 64'(fifo.count), 64'd0);
    check("t6_queue_left", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
